// File: rtl/ram_write_merger.sv
// Merges two same-cycle RAM write ports onto one registered single-port RAM write,
// queuing the overflow in a small FIFO and offering an end-of-frame flush handshake.
module ram_write_merger #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iWrEn1,
  input  logic [ADDR_W-1:0] iWrAddr1,
  input  logic [DATA_W-1:0] iWrData1,
  input  logic              iWrEn2,
  input  logic [ADDR_W-1:0] iWrAddr2,
  input  logic [DATA_W-1:0] iWrData2,
  input  logic              iFlush,
  output logic              oRamEnable,
  output logic [ADDR_W-1:0] oRamAddress,
  output logic [DATA_W-1:0] oRamData,
  output logic [PTR_W:0]    oLevel,
  output logic              oOverflow,
  output logic              oFlushDone
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count, count_next, occ_a, occ_b;
  state_t           state, state_next;
  entry_t           port1, port2, head, slot, push_a, push_b;
  logic             pop, slot_valid, push_a_valid, push_b_valid;
  logic             accept_a, accept_b, drop;

  assign port1 = {iWrAddr1, iWrData1};
  assign port2 = {iWrAddr2, iWrData2};
  assign head  = mem[rd_ptr];

  // Slot goes to the oldest source (head, port 1, port 2); the rest queue in that order.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pop          = (count != '0);
    slot_valid   = 1'b1;
    slot         = head;
    push_a_valid = 1'b0;
    push_a       = port2;
    push_b_valid = 1'b0;
    push_b       = port2;
    if (pop) begin
      if (iWrEn1) begin
        push_a_valid = 1'b1;
        push_a       = port1;
        push_b_valid = iWrEn2;
      end else begin
        push_a_valid = iWrEn2;
      end
    end else if (iWrEn1) begin
      slot         = port1;
      push_a_valid = iWrEn2;
    end else begin
      slot       = port2;
      slot_valid = iWrEn2;
    end

    occ_a      = count - {{PTR_W{1'b0}}, pop};
    accept_a   = push_a_valid && (occ_a < FULL);
    occ_b      = occ_a + {{PTR_W{1'b0}}, accept_a};
    accept_b   = push_b_valid && (occ_b < FULL);
    drop       = (push_a_valid && !accept_a) || (push_b_valid && !accept_b);
    count_next = occ_b + {{PTR_W{1'b0}}, accept_b};
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (iFlush) state_next = DRAIN;
      DRAIN:   if (count_next == '0 && !iWrEn1 && !iWrEn2) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge iClock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (iReset) begin
      state     <= RUN;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      oOverflow <= 1'b0;
    end else if (iEnable) begin
      state  <= state_next;
      count  <= count_next;
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(accept_a) + PTR_W'(accept_b);
      if (drop) oOverflow <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge iClock) begin
    if (iEnable && !iReset) begin
      if (accept_a) mem[wr_ptr] <= push_a;
      if (accept_b) mem[wr_ptr + PTR_W'(1)] <= push_b;
    end
  end

  // Address and data only move on a real write so the RAM bus stays quiet when idle.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oRamEnable  <= 1'b0;
      oRamAddress <= '0;
      oRamData    <= '0;
    end else if (!iEnable) begin
      oRamEnable <= 1'b0;
    end else begin
      oRamEnable <= slot_valid;
      if (slot_valid) begin
        oRamAddress <= slot.addr;
        oRamData    <= slot.data;
      end
    end
  end

  assign oLevel     = count;
  assign oFlushDone = (state == DONE);

endmodule

// File: tb/tb_ram_write_merger.sv
// Self-checking bench for ram_write_merger: directed vector table, hand-written
// flush/freeze/reset sequences, and random traffic against a queue-based model.
module tb_ram_write_merger;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic              clk = 1'b0;
  logic              rst, en, we1, we2, flush;
  logic [ADDR_W-1:0] a1, a2;
  logic [DATA_W-1:0] d1, d2;
  logic              ram_en, ovf, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [PTR_W:0]    level;

  always #5 clk = ~clk;

  ram_write_merger #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .iClock(clk), .iReset(rst), .iEnable(en),
    .iWrEn1(we1), .iWrAddr1(a1), .iWrData1(d1),
    .iWrEn2(we2), .iWrAddr2(a2), .iWrData2(d2),
    .iFlush(flush),
    .oRamEnable(ram_en), .oRamAddress(ram_addr), .oRamData(ram_data),
    .oLevel(level), .oOverflow(ovf), .oFlushDone(done)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Reference model: queue of pending writes, sticky overflow, flush phase (0 run, 1 drain, 2 done).
  wr_t mq[$];
  bit  m_en, m_ovf;
  int  m_phase;
  wr_t m_last;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit s_en, input bit s_w1, input logic [15:0] s_a1, input logic [15:0] s_d1,
                      input bit s_w2, input logic [15:0] s_a2, input logic [15:0] s_d2,
                      input bit s_fl, input bit s_rst);
    wr_t reqs[$];
    en = s_en; we1 = s_w1; a1 = s_a1; d1 = s_d1;
    we2 = s_w2; a2 = s_a2; d2 = s_d2; flush = s_fl; rst = s_rst;
    @(posedge clk);
    if (s_rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_phase = 0;
      m_en    = 1'b0;
      m_last  = '{addr: '0, data: '0};
    end else if (!s_en) begin
      m_en = 1'b0;
    end else begin
      if (s_w1) reqs.push_back('{addr: s_a1, data: s_d1});
      if (s_w2) reqs.push_back('{addr: s_a2, data: s_d2});
      m_en = 1'b0;
      if (mq.size() > 0) begin
        m_last = mq.pop_front();
        m_en   = 1'b1;
      end else if (reqs.size() > 0) begin
        m_last = reqs.pop_front();
        m_en   = 1'b1;
      end
      foreach (reqs[i]) begin
        if (mq.size() < DEPTH) mq.push_back(reqs[i]);
        else m_ovf = 1'b1;
      end
      case (m_phase)
        0:       if (s_fl) m_phase = 1;
        1:       if (mq.size() == 0 && !s_w1 && !s_w2) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    #1;
    check("ram_enable", ram_en, m_en);
    if (m_en || s_rst) begin
      check("ram_address", ram_addr, m_last.addr);
      check("ram_data", ram_data, m_last.data);
    end
    check("level", level, mq.size());
    check("overflow", ovf, m_ovf);
    check("flush_done", done, m_phase == 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          en, w1;
    logic [15:0] a1, d1;
    bit          w2;
    logic [15:0] a2, d2;
    bit          fl;
    bit          x_en;
    logic [15:0] x_addr, x_data;
    int          x_lvl;
    bit          x_done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 1, 16'h0010, 16'hBEEF, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 16'h0020, 16'h1111, 1, 16'h0021, 16'h2222, 0, 1, 16'h0020, 16'h1111, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0021, 16'h2222, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 16'h0030, 16'h3333, 0, 1, 16'h0030, 16'h3333, 0, 0};
    tbl[6]  = '{0, 1, 16'h0040, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    {rst, en, we1, we2, flush} = 5'b10000;
    {a1, a2, d1, d2} = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);

    // Directed vectors: single, dual, port-2-only, frozen request, empty flush.
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].w2, tbl[i].a2, tbl[i].d2, tbl[i].fl, 0);
      check("tbl_ram_enable", ram_en, tbl[i].x_en);
      if (tbl[i].x_en) begin
        check("tbl_ram_address", ram_addr, tbl[i].x_addr);
        check("tbl_ram_data", ram_data, tbl[i].x_data);
      end
      check("tbl_level", level, tbl[i].x_lvl);
      check("tbl_flush_done", done, tbl[i].x_done);
    end

    // Burst: eight dual cycles fill the FIFO, the ninth drops port 2.
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 16'h0100 + 16'(2*i), 16'hA000 + 16'(i), 1, 16'h0101 + 16'(2*i), 16'hB000 + 16'(i), 0, 0);
      check("burst_level", level, i + 1);
      check("burst_no_overflow", ovf, 0);
    end
    step(1, 1, 16'h0110, 16'hA008, 1, 16'h0111, 16'hB008, 0, 0);
    check("burst_full_level", level, DEPTH);
    check("burst_overflow", ovf, 1);
    idle(10);
    check("burst_drained", level, 0);
    check("overflow_sticky", ovf, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("overflow_cleared", ovf, 0);

    // Flush with three queued entries: the third strobe arrives with the done pulse.
    for (int i = 0; i < 3; i++)
      step(1, 1, 16'h0200 + 16'(2*i), 16'hC000 + 16'(i), 1, 16'h0201 + 16'(2*i), 16'hD000 + 16'(i), 0, 0);
    check("flush_pre_level", level, 3);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    check("flush_w1", ram_en, 1);
    check("flush_w1_addr", ram_addr, 16'h0203);
    check("flush_w1_done", done, 0);
    idle(1);
    check("flush_w2_addr", ram_addr, 16'h0204);
    check("flush_w2_done", done, 0);
    idle(1);
    check("flush_w3_addr", ram_addr, 16'h0205);
    check("flush_last_done", done, 1);
    check("flush_last_level", level, 0);
    idle(1);
    check("flush_done_pulse", done, 0);
    check("flush_quiet", ram_en, 0);

    // Freeze at level 4, then reset mid-drain.
    for (int i = 0; i < 4; i++)
      step(1, 1, 16'h0300 + 16'(2*i), 16'hE000 + 16'(i), 1, 16'h0301 + 16'(2*i), 16'hF000 + 16'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 16'h0400, 16'h5555, 1, 16'h0401, 16'h6666, 0, 0);
      check("freeze_no_write", ram_en, 0);
      check("freeze_level", level, 4);
    end
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("reset_ram_enable", ram_en, 0);
    check("reset_address", ram_addr, 0);
    check("reset_data", ram_data, 0);
    check("reset_level", level, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("reset_no_done", done, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(7) != 0), $urandom_range(1), 16'($urandom), 16'($urandom),
           $urandom_range(1), 16'($urandom), 16'($urandom),
           ($urandom_range(31) == 0), ($urandom_range(127) == 0));
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
